// File: rtl/risc_v_mike_instr_mem_ctrl.sv
// Instruction memory controller: zero-fills DEPTH words after reset, then serves
// PC fetches and accepts program-load writes.
// Latency: one cycle from accepted fetch to registered response.
// Backpressure: a stalled response (rsp_valid & !rsp_ready) parks the FSM in HOLD,
// where fetch_ready stays low until the response is consumed.
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-low reset
//   ld_we/addr/data  - program-load write (byte address, word aligned only)
//   fetch_req/addr   - fetch request (byte address), accepted with fetch_ready
//   rsp_valid/ready  - response handshake; rsp_data / rsp_err carry the result
//   init_done        - high once zero-fill has finished
module risc_v_mike_instr_mem_ctrl #(
   parameter int                 INSTR_W  = 32,
   parameter int                 DEPTH    = 1024,
   parameter int                 ADDR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_WORD = 32'h00000013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_we,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               fetch_req,
   input  logic [ADDR_W-1:0]  fetch_addr,
   output logic               fetch_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [INSTR_W-1:0] rsp_data,
   output logic [1:0]         rsp_err,
   output logic               init_done
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [INSTR_W-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]         rsp_err_q, rsp_err_d;

   logic [INSTR_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0]  fetch_widx, ld_widx;
   logic               fetch_mis, fetch_oor;
   logic               ld_mis, ld_oor, ld_ok;
   logic               accept;
   logic [INSTR_W-1:0] rd_word;

   // Word index and error classification for both address ports. The full-width
   // compare catches any high address bit beyond the array.
   assign fetch_widx = fetch_addr >> 2;
   assign fetch_mis  = |fetch_addr[1:0];
   assign fetch_oor  = fetch_widx >= ADDR_W'(DEPTH);

   assign ld_widx = ld_addr >> 2;
   assign ld_mis  = |ld_addr[1:0];
   assign ld_oor  = ld_widx >= ADDR_W'(DEPTH);
   assign ld_ok   = ld_we && (state_q != INIT) && !ld_mis && !ld_oor;

   assign fetch_ready = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
   assign accept      = fetch_req && fetch_ready;
   assign init_done   = (state_q != INIT);

   // Combinational read captured into the response register at the same edge a
   // load may write, so a same-cycle load/fetch to one word returns the old word.
   assign rd_word = mem[fetch_widx[IDX_W-1:0]];

   // Storage: zero-fill owns the write port during INIT, loads afterwards.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem[cnt_q] <= '0;
      end else if (ld_ok) begin
         mem[ld_widx[IDX_W-1:0]] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = {fetch_oor, fetch_mis};
               rsp_data_d  = (fetch_oor || fetch_mis) ? NOP_WORD : rd_word;
            end else if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
            end else if (rsp_valid_q) begin
               // Consumer stalled: freeze the response until it is taken.
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               state_d     = RUN;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule
